// File: rtl/mult_sched_pkg.sv
// Shared constants and types for the multiplier scheduler.
// Covers the operand/product widths, datapath latency, the tag layout and the response entry layout.
package mult_sched_pkg;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int PW    = 2 * WIDTH;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;
    localparam int IDW   = $clog2(NREQ);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  p;
    } resp_t;

    // Round-robin successor of a granted port, wrapping NREQ-1 back to 0.
    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
        logic [IDW-1:0] nxt;
        if (int'(id) == NREQ - 1) begin
            nxt = {IDW{1'b0}};
        end else begin
            nxt = id + IDW'(1'b1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mult_resp_fifo.sv
// In-order circular response buffer: wrap pointers plus an occupancy count.
// Head data reads as zero while the buffer is empty.
module mult_resp_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 34
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [DW-1:0]                i_din,
    input  logic                         i_pop,
    output logic [DW-1:0]                o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (int'(p) == DEPTH - 1) ? {AW{1'b0}} : p + AW'(1'b1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = o_empty ? {DW{1'b0}} : r_mem[r_rd];

    // Storage array; contents are only meaningful between rd and wr.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= {AW{1'b0}};
            r_rd    <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Shares one fixed-latency multiplier datapath among NREQ requesters.
// Round-robin grant, registered issue, tag pipe aligned to the datapath, credit-guarded response FIFO.
module mult_sched
    import mult_sched_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    input  logic [NREQ-1:0]       i_req_signed,
    output logic                  o_mul_issue,
    output logic [WIDTH-1:0]      o_mul_a,
    output logic [WIDTH-1:0]      o_mul_b,
    output logic                  o_mul_signed,
    input  logic [PW-1:0]         i_mul_p,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [IDW-1:0]        o_resp_id,
    output logic [PW-1:0]         o_resp_p,
    output logic                  o_busy
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_ptr;
    logic             r_busy;
    logic             r_issue;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    tag_t             r_tag [0:LAT];

    logic             w_grant_vld;
    logic [IDW-1:0]   w_grant_id;
    logic [IDW-1:0]   w_idx;
    logic             w_accept;
    logic             w_pop;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_signed;
    logic             w_fifo_push;
    resp_t            w_fifo_din;
    resp_t            w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW-1:0]    w_fifo_count;
    logic             w_unused;

    // Round-robin search: first valid port at or after the pointer.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = {IDW{1'b0}};
        w_idx       = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_idx       = IDW'((int'(r_ptr) + k) % NREQ);
            w_grant_id  = (!w_grant_vld && i_req_valid[w_idx]) ? w_idx : w_grant_id;
            w_grant_vld = w_grant_vld | i_req_valid[w_idx];
        end
    end

    // The credit check deliberately ignores a same-cycle response pop.
    assign w_accept = w_grant_vld && !i_rst && (r_cnt < CW'(DEPTH));
    assign w_pop    = o_resp_valid && i_resp_ready;

    // One-hot ready plus operand selection for the granted port.
    always_comb begin
        o_req_ready  = {NREQ{1'b0}};
        w_sel_a      = {WIDTH{1'b0}};
        w_sel_b      = {WIDTH{1'b0}};
        w_sel_signed = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            o_req_ready[i] = w_accept && (w_grant_id == IDW'(i));
            w_sel_a        = (w_grant_id == IDW'(i)) ? i_req_a[i*WIDTH +: WIDTH] : w_sel_a;
            w_sel_b        = (w_grant_id == IDW'(i)) ? i_req_b[i*WIDTH +: WIDTH] : w_sel_b;
            w_sel_signed   = (w_grant_id == IDW'(i)) ? i_req_signed[i] : w_sel_signed;
        end
    end

    // Credit counter next value.
    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_accept, w_pop})
            2'b10:   w_cnt_next = r_cnt + CW'(1'b1);
            2'b01:   w_cnt_next = r_cnt - CW'(1'b1);
            default: w_cnt_next = r_cnt;
        endcase
    end

    // Credit, pointer and issue registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= {CW{1'b0}};
            r_ptr    <= {IDW{1'b0}};
            r_busy   <= 1'b0;
            r_issue  <= 1'b0;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_signed <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_cnt_next != {CW{1'b0}});
            r_issue <= w_accept;
            if (w_accept) begin
                r_ptr    <= rr_next(w_grant_id);
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_signed <= w_sel_signed;
            end
        end
    end

    // Tag pipe: stage LAT is aligned with the product on i_mul_p.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s <= LAT; s++) begin
                r_tag[s] <= '{vld: 1'b0, id: {IDW{1'b0}}};
            end
        end else begin
            r_tag[0] <= '{vld: w_accept, id: w_grant_id};
            for (int s = 1; s <= LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_fifo_push = r_tag[LAT].vld;
    assign w_fifo_din  = '{id: r_tag[LAT].id, p: i_mul_p};

    mult_resp_fifo #(
        .DEPTH (DEPTH),
        .DW    (IDW + PW)
    ) u_resp_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_fifo_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_unused     = ^{w_fifo_full, w_fifo_count};
    assign o_mul_issue  = r_issue;
    assign o_mul_a      = r_a;
    assign o_mul_b      = r_b;
    assign o_mul_signed = r_signed;
    assign o_resp_valid = !w_fifo_empty;
    assign o_resp_id    = w_fifo_dout.id;
    assign o_resp_p     = w_fifo_dout.p;
    assign o_busy       = r_busy;

endmodule
